// File: rtl/pwm_timer.sv
// PWM generator / one-shot timer advanced by rising edges of a divided slow clock.
// Define PWM_TIMER_SHADOW_EN to latch period/duty at run start and on every wrap.
module pwm_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_slow_clk,
  input  logic             i_en,
  input  logic             i_mode,
  input  logic [CNT_W-1:0] i_period,
  input  logic [CNT_W-1:0] i_duty,
  input  logic             i_irq_clr,
  output logic             o_pwm,
  output logic             o_irq,
  output logic [CNT_W-1:0] o_count,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [CNT_W-1:0] period_act, duty_act;
  logic             slow_q;
  logic             tick;
  logic             irq_set;

  assign tick    = i_slow_clk & ~slow_q;
  assign o_count = count;
  assign o_busy  = (state == RUN);

`ifdef PWM_TIMER_SHADOW_EN
  logic [CNT_W-1:0] period_sh, duty_sh;
  logic             load_shadow;

  // Reload on run entry and on a PWM wrap that keeps us in RUN.
  always_comb begin
    load_shadow = ((state == IDLE) && (state_nxt == RUN)) ||
                  (irq_set && (state_nxt == RUN));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      period_sh <= '0;
      duty_sh   <= '0;
    end else if (load_shadow) begin
      period_sh <= i_period;
      duty_sh   <= i_duty;
    end
  end

  assign period_act = period_sh;
  assign duty_act   = duty_sh;
`else
  assign period_act = i_period;
  assign duty_act   = i_duty;
`endif

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    irq_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_en && (i_period >= TWO)) begin
          state_nxt = RUN;
          count_nxt = '0;
        end
      end
      RUN: begin
        if (!i_en || (period_act < TWO)) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end else if (tick && (count >= period_act - ONE)) begin
          // >= also catches an unshadowed period shrinking below count+1
          irq_set = 1'b1;
          if (i_mode) begin
            state_nxt = DONE;
            count_nxt = period_act - ONE;
          end else begin
            count_nxt = '0;
          end
        end else if (tick) begin
          count_nxt = count + ONE;
        end
      end
      DONE: begin
        if (!i_en) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      count  <= '0;
      slow_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      slow_q <= i_slow_clk;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pwm <= 1'b0;
      o_irq <= 1'b0;
    end else begin
      o_pwm <= (state == RUN) && !i_mode && (count < duty_act);
      if (irq_set)
        o_irq <= 1'b1;
      else if (i_irq_clr)
        o_irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_timer.sv
// Scoreboard bench for pwm_timer; expected count/pwm/irq/busy are derived from tick numbers.
module tb_pwm_timer;

  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             slow_clk;
  logic             en;
  logic             mode;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] duty;
  logic             irq_clr;
  logic             o_pwm;
  logic             o_irq;
  logic [CNT_W-1:0] o_count;
  logic             o_busy;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             pwm;
    logic             irq;
    logic             busy;
  } exp_t;

  exp_t        sb[$];
  exp_t        e, a;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  pwm_timer #(.CNT_W(CNT_W)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_slow_clk (slow_clk),
    .i_en       (en),
    .i_mode     (mode),
    .i_period   (period),
    .i_duty     (duty),
    .i_irq_clr  (irq_clr),
    .o_pwm      (o_pwm),
    .o_irq      (o_irq),
    .o_count    (o_count),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input logic s);
    slow_clk = s;
    @(posedge clk);
    #1;
  endtask

  task automatic tick_window(input int len);
    step(1'b1);
    for (int i = 1; i < len; i++) step(1'b0);
  endtask

  task automatic quiesce();
    en      = 1'b0;
    irq_clr = 1'b1;
    step(1'b0);
    irq_clr = 1'b0;
    step(1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; slow_clk = 1'b0;
    period = '0; duty = '0; irq_clr = 1'b0;
    repeat (30) step(1'b0);
    a = {o_count, o_pwm, o_irq, o_busy};
    n_cmp++;
    if (a !== '0) begin
      n_err++;
      $display("FAIL reset_hold got=%h want=0", a);
    end
    rst_n = 1'b1;
    step(1'b0);
    a = {o_count, o_pwm, o_irq, o_busy};
    n_cmp++;
    if (a !== '0) begin
      n_err++;
      $display("FAIL reset_release got=%h want=0", a);
    end
  endtask

  task automatic test_pwm();
    quiesce();
    period = 16'd4; duty = 16'd1; mode = 1'b0; en = 1'b1;
    step(1'b0);
    step(1'b0);
    sb.push_back({16'd0, 1'b1, 1'b0, 1'b1});
    e = sb.pop_front(); a = {o_count, o_pwm, o_irq, o_busy};
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL pwm_start got cnt=%0d pwm=%b irq=%b busy=%b want cnt=%0d pwm=%b irq=%b busy=%b",
               a.cnt, a.pwm, a.irq, a.busy, e.cnt, e.pwm, e.irq, e.busy);
    end
    for (int k = 1; k <= 9; k++) begin
      sb.push_back({CNT_W'(k % 4), (k % 4) < 1, k >= 4, 1'b1});
      tick_window(5);
      e = sb.pop_front(); a = {o_count, o_pwm, o_irq, o_busy};
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL pwm_tick%0d got cnt=%0d pwm=%b irq=%b busy=%b want cnt=%0d pwm=%b irq=%b busy=%b",
                 k, a.cnt, a.pwm, a.irq, a.busy, e.cnt, e.pwm, e.irq, e.busy);
      end
    end
  endtask

  task automatic test_oneshot();
    quiesce();
    period = 16'd3; duty = 16'd1; mode = 1'b1; en = 1'b1;
    step(1'b0);
    step(1'b0);
    for (int k = 0; k <= 5; k++) begin
      sb.push_back({CNT_W'((k < 3) ? k : 2), 1'b0, k >= 3, k < 3});
      if (k > 0) tick_window(5);
      e = sb.pop_front(); a = {o_count, o_pwm, o_irq, o_busy};
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL oneshot_tick%0d got cnt=%0d pwm=%b irq=%b busy=%b want cnt=%0d pwm=%b irq=%b busy=%b",
                 k, a.cnt, a.pwm, a.irq, a.busy, e.cnt, e.pwm, e.irq, e.busy);
      end
    end
    en = 1'b0;
    sb.push_back({16'd0, 1'b0, 1'b1, 1'b0});
    step(1'b0);
    e = sb.pop_front(); a = {o_count, o_pwm, o_irq, o_busy};
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL oneshot_disable got cnt=%0d irq=%b busy=%b want cnt=%0d irq=%b busy=%b",
               a.cnt, a.irq, a.busy, e.cnt, e.irq, e.busy);
    end
  endtask

  task automatic test_invalid();
    quiesce();
    period = 16'd0; duty = 16'd1; mode = 1'b0; en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k == 10) period = 16'd1;
      sb.push_back('0);
      tick_window(3);
      e = sb.pop_front(); a = {o_count, o_pwm, o_irq, o_busy};
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL invalid_p%0d_t%0d got cnt=%0d pwm=%b irq=%b busy=%b want all zero",
                 period, k, a.cnt, a.pwm, a.irq, a.busy);
      end
    end
  endtask

  task automatic test_duty_extremes();
    quiesce();
    period = 16'd4; duty = 16'd0; mode = 1'b0; en = 1'b1;
    step(1'b0);
    for (int c = 0; c < 20; c++) begin
      step(c % 2 == 0);
      n_cmp++;
      if (o_pwm !== 1'b0 || o_busy !== 1'b1) begin
        n_err++;
        $display("FAIL duty0_c%0d got pwm=%b busy=%b want pwm=0 busy=1", c, o_pwm, o_busy);
      end
    end
    quiesce();
    period = 16'd5; duty = 16'd7; en = 1'b1;
    step(1'b0);
    for (int c = 0; c < 20; c++) begin
      step(c % 2 == 0);
      n_cmp++;
      if (o_pwm !== 1'b1 || o_busy !== 1'b1) begin
        n_err++;
        $display("FAIL duty_full_c%0d got pwm=%b busy=%b want pwm=1 busy=1", c, o_pwm, o_busy);
      end
    end
  endtask

  task automatic test_irq_collision();
    quiesce();
    period = 16'd2; duty = 16'd1; mode = 1'b0; en = 1'b1;
    step(1'b0);
    tick_window(2);
    irq_clr = 1'b1;
    step(1'b1);
    irq_clr = 1'b0;
    step(1'b0);
    n_cmp++;
    if (o_irq !== 1'b1) begin
      n_err++;
      $display("FAIL irq_set_vs_clr got irq=%b want 1", o_irq);
    end
    irq_clr = 1'b1;
    step(1'b0);
    irq_clr = 1'b0;
    n_cmp++;
    if (o_irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_clear got irq=%b want 0", o_irq);
    end
  endtask

  task automatic test_reset_mid_run();
    quiesce();
    period = 16'd10; duty = 16'd5; mode = 1'b0; en = 1'b1;
    step(1'b0);
    repeat (3) tick_window(3);
    rst_n = 1'b0;
    #1;
    a = {o_count, o_pwm, o_irq, o_busy};
    n_cmp++;
    if (a !== '0) begin
      n_err++;
      $display("FAIL reset_mid_run got=%h want=0", a);
    end
    en = 1'b0;
    repeat (4) tick_window(2);
    rst_n = 1'b1;
    repeat (3) tick_window(2);
    a = {o_count, o_pwm, o_irq, o_busy};
    n_cmp++;
    if (a !== '0) begin
      n_err++;
      $display("FAIL reset_mid_run_after got=%h want=0", a);
    end
  endtask

`ifdef PWM_TIMER_SHADOW_EN
  task automatic test_shadow();
    quiesce();
    period = 16'd100; duty = 16'd50; mode = 1'b0; en = 1'b1;
    step(1'b0);
    step(1'b0);
    for (int k = 1; k <= 130; k++) begin
      if (k == 21) duty = 16'd10;
      sb.push_back({CNT_W'(k % 100), (k < 100) ? ((k % 100) < 50) : ((k % 100) < 10),
                    k >= 100, 1'b1});
      tick_window(2);
      e = sb.pop_front(); a = {o_count, o_pwm, o_irq, o_busy};
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL shadow_tick%0d got cnt=%0d pwm=%b irq=%b want cnt=%0d pwm=%b irq=%b",
                 k, a.cnt, a.pwm, a.irq, e.cnt, e.pwm, e.irq);
      end
    end
  endtask
`else
  task automatic test_period_shrink();
    quiesce();
    period = 16'd10; duty = 16'd3; mode = 1'b0; en = 1'b1;
    step(1'b0);
    step(1'b0);
    for (int k = 1; k <= 10; k++) begin
      if (k == 8) period = 16'd5;
      if (k <= 7) sb.push_back({CNT_W'(k), k < 3, 1'b0, 1'b1});
      else        sb.push_back({CNT_W'(k - 8), (k - 8) < 3, 1'b1, 1'b1});
      tick_window(3);
      e = sb.pop_front(); a = {o_count, o_pwm, o_irq, o_busy};
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL shrink_tick%0d got cnt=%0d pwm=%b irq=%b want cnt=%0d pwm=%b irq=%b",
                 k, a.cnt, a.pwm, a.irq, e.cnt, e.pwm, e.irq);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_pwm();
    test_oneshot();
    test_invalid();
    test_duty_extremes();
    test_irq_collision();
    test_reset_mid_run();
`ifdef PWM_TIMER_SHADOW_EN
    test_shadow();
`else
    test_period_shrink();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
